mmio_csr_responder: RTL and testbench

MMIO_CSR_RESPONDER -- requirements
Module: mmio_csr_responder

---
 rtl/mmio_csr_responder.sv | 178 +++++++++++++++++
 tb/tb_mmio_csr_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_csr_responder.sv
// MMIO CSR responder: AFU identification registers, scratch/buffer CSRs and a
// start/abort/done control handshake with a two-cycle pipelined read path.
module mmio_csr_responder #(
    parameter logic [63:0] AFU_ID_L  = 64'h0,
    parameter logic [63:0] AFU_ID_H  = 64'h0,
    parameter logic [63:0] DFH_VALUE = 64'h1000_0000_0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_rd_valid,
    input  logic        cfg_wr_valid,
    input  logic [15:0] cfg_addr,
    input  logic [8:0]  cfg_tid,
    input  logic [63:0] cfg_wdata,
    output logic        rsp_valid,
    output logic [8:0]  rsp_tid,
    output logic [63:0] rsp_data,
    output logic        core_start,
    output logic        core_abort,
    output logic [63:0] buf_addr,
    input  logic        core_done
);

    localparam logic [14:0] IDX_DFH     = 15'd0;
    localparam logic [14:0] IDX_ID_L    = 15'd1;
    localparam logic [14:0] IDX_ID_H    = 15'd2;
    localparam logic [14:0] IDX_SCRATCH = 15'd8;
    localparam logic [14:0] IDX_BUF     = 15'd9;
    localparam logic [14:0] IDX_CTRL    = 15'd10;
    localparam logic [14:0] IDX_STATUS  = 15'd11;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_r;
    logic [63:0] scratch_r;
    logic [63:0] buf_addr_r;
    logic        done_r;
    logic        start_err_r;
    logic [31:0] done_count_r;

    logic        p1_valid_r;
    logic [8:0]  p1_tid_r;
    logic [63:0] p1_data_r;

    logic [14:0] idx_s;
    logic [63:0] status_s;
    logic [63:0] rd_mux_s;
    logic        scratch_we_s;
    logic        buf_we_s;
    logic        start_req_s;
    logic        abort_req_s;
    logic        clear_err_s;

    assign idx_s    = cfg_addr[15:1];
    assign status_s = {done_count_r, 29'd0, start_err_r, done_r, (state_r == BUSY)};
    assign buf_addr = buf_addr_r;

    // Read data selection; sampled from current register values, so a
    // coincident write is not yet visible to the read.
    always_comb begin
        rd_mux_s = 64'd0;
        case (idx_s)
            IDX_DFH:     rd_mux_s = DFH_VALUE;
            IDX_ID_L:    rd_mux_s = AFU_ID_L;
            IDX_ID_H:    rd_mux_s = AFU_ID_H;
            IDX_SCRATCH: rd_mux_s = scratch_r;
            IDX_BUF:     rd_mux_s = buf_addr_r;
            IDX_STATUS:  rd_mux_s = status_s;
            default:     rd_mux_s = 64'd0;
        endcase
    end

    // Write decode; a combined start+abort command is treated as abort only.
    always_comb begin
        scratch_we_s = 1'b0;
        buf_we_s     = 1'b0;
        start_req_s  = 1'b0;
        abort_req_s  = 1'b0;
        clear_err_s  = 1'b0;
        if (cfg_wr_valid) begin
            scratch_we_s = (idx_s == IDX_SCRATCH);
            buf_we_s     = (idx_s == IDX_BUF);
            if (idx_s == IDX_CTRL) begin
                abort_req_s = cfg_wdata[1];
                start_req_s = cfg_wdata[0] & ~cfg_wdata[1];
                clear_err_s = cfg_wdata[2];
            end else begin
                abort_req_s = 1'b0;
            end
        end else begin
            scratch_we_s = 1'b0;
        end
    end

    // Read response pipeline: request stage then output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_valid_r <= 1'b0;
            p1_tid_r   <= 9'd0;
            p1_data_r  <= 64'd0;
            rsp_valid  <= 1'b0;
            rsp_tid    <= 9'd0;
            rsp_data   <= 64'd0;
        end else begin
            p1_valid_r <= cfg_rd_valid;
            p1_tid_r   <= cfg_tid;
            p1_data_r  <= rd_mux_s;
            rsp_valid  <= p1_valid_r;
            rsp_tid    <= p1_tid_r;
            rsp_data   <= p1_data_r;
        end
    end

    // Read/write data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            scratch_r  <= 64'd0;
            buf_addr_r <= 64'd0;
        end else begin
            if (scratch_we_s) begin
                scratch_r <= cfg_wdata;
            end
            if (buf_we_s) begin
                buf_addr_r <= cfg_wdata;
            end
        end
    end

    // Core control FSM with status tracking; start is judged on pre-cycle state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            core_start   <= 1'b0;
            core_abort   <= 1'b0;
            done_r       <= 1'b0;
            start_err_r  <= 1'b0;
            done_count_r <= 32'd0;
        end else begin
            core_start <= 1'b0;
            core_abort <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_req_s) begin
                        state_r    <= BUSY;
                        core_start <= 1'b1;
                        done_r     <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (abort_req_s) begin
                        state_r    <= IDLE;
                        core_abort <= 1'b1;
                    end else if (core_done) begin
                        state_r      <= IDLE;
                        done_r       <= 1'b1;
                        done_count_r <= done_count_r + 32'd1;
                    end else begin
                        state_r <= BUSY;
                    end
                end
                default: state_r <= IDLE;
            endcase
            if (start_req_s && (state_r == BUSY)) begin
                start_err_r <= 1'b1;
            end else if (clear_err_s) begin
                start_err_r <= 1'b0;
            end else begin
                start_err_r <= start_err_r;
            end
        end
    end

endmodule

// File: tb/tb_mmio_csr_responder.sv
// Self-checking bench for mmio_csr_responder: table-driven CSR accesses with a
// read-response scoreboard, plus hand-written control-handshake sequences.
module tb_mmio_csr_responder;

    localparam logic [63:0] ID_L = 64'h1122_3344_5566_7788;
    localparam logic [63:0] ID_H = 64'h99AA_BBCC_DDEE_FF00;
    localparam logic [63:0] DFH  = 64'h1000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_rd_valid = 1'b0;
    logic        cfg_wr_valid = 1'b0;
    logic [15:0] cfg_addr = 16'd0;
    logic [8:0]  cfg_tid = 9'd0;
    logic [63:0] cfg_wdata = 64'd0;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;
    logic        core_start;
    logic        core_abort;
    logic [63:0] buf_addr;
    logic        core_done = 1'b0;

    mmio_csr_responder #(.AFU_ID_L(ID_L), .AFU_ID_H(ID_H), .DFH_VALUE(DFH)) dut (
        .clk(clk), .rst(rst), .cfg_rd_valid(cfg_rd_valid), .cfg_wr_valid(cfg_wr_valid),
        .cfg_addr(cfg_addr), .cfg_tid(cfg_tid), .cfg_wdata(cfg_wdata),
        .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
        .core_start(core_start), .core_abort(core_abort), .buf_addr(buf_addr),
        .core_done(core_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [8:0]  tid;
        logic [63:0] wdata;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [8:0]  tid;
        logic [63:0] data;
        int          due;
    } exp_t;

    vec_t vecs[16];
    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock; outputs are examined 1 time unit after the rising edge.
    task automatic step();
        bit ev;
        @(posedge clk);
        #1;
        cyc++;
        ev = (sb.size() > 0) && (sb[0].due == cyc);
        chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, ev});
        if (ev) begin
            chk("rsp_tid", {55'd0, rsp_tid}, {55'd0, sb[0].tid});
            chk("rsp_data", rsp_data, sb[0].data);
            void'(sb.pop_front());
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [8:0] tid, input logic [63:0] wdata, input logic [63:0] exp);
        exp_t e;
        cfg_rd_valid = rd;
        cfg_wr_valid = wr;
        cfg_addr     = addr;
        cfg_tid      = tid;
        cfg_wdata    = wdata;
        if (rd) begin
            e.tid  = tid;
            e.data = exp;
            e.due  = cyc + 2;
            sb.push_back(e);
        end
        step();
        cfg_rd_valid = 1'b0;
        cfg_wr_valid = 1'b0;
    endtask

    task automatic ctrl_write(input logic [63:0] val);
        drive(1'b0, 1'b1, 16'h0014, 9'd0, val, 64'd0);
    endtask

    task automatic read_status(input logic [8:0] tid, input logic [63:0] exp);
        drive(1'b1, 1'b0, 16'h0016, tid, 64'd0, exp);
    endtask

    task automatic done_pulse();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 16'h0002, 9'h1A5, 64'd0, ID_L};
        vecs[1]  = '{1'b1, 1'b0, 16'h0000, 9'h001, 64'd0, DFH};
        vecs[2]  = '{1'b1, 1'b0, 16'h0004, 9'h002, 64'd0, ID_H};
        vecs[3]  = '{1'b1, 1'b0, 16'h0003, 9'h003, 64'd0, ID_L};
        vecs[4]  = '{1'b1, 1'b0, 16'h0006, 9'h004, 64'd0, 64'd0};
        vecs[5]  = '{1'b1, 1'b0, 16'h0008, 9'h005, 64'd0, 64'd0};
        vecs[6]  = '{1'b0, 1'b1, 16'h0010, 9'h000, 64'hDEAD_BEEF_0123_4567, 64'd0};
        vecs[7]  = '{1'b1, 1'b0, 16'h0010, 9'h006, 64'd0, 64'hDEAD_BEEF_0123_4567};
        vecs[8]  = '{1'b1, 1'b0, 16'h0020, 9'h007, 64'd0, 64'd0};
        vecs[9]  = '{1'b1, 1'b1, 16'h0012, 9'h008, 64'hA5A5_A5A5_5A5A_5A5A, 64'd0};
        vecs[10] = '{1'b1, 1'b0, 16'h0012, 9'h009, 64'd0, 64'hA5A5_A5A5_5A5A_5A5A};
        vecs[11] = '{1'b0, 1'b1, 16'h0016, 9'h000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        vecs[12] = '{1'b1, 1'b0, 16'h0016, 9'h00A, 64'd0, 64'd0};
        vecs[13] = '{1'b0, 1'b1, 16'h0020, 9'h000, 64'h1234_5678_9ABC_DEF0, 64'd0};
        vecs[14] = '{1'b1, 1'b0, 16'h0014, 9'h00B, 64'd0, 64'd0};
        vecs[15] = '{1'b1, 1'b0, 16'h0011, 9'h1FF, 64'd0, 64'hDEAD_BEEF_0123_4567};

        // Reset, with a request presented during reset that must be ignored.
        cfg_rd_valid = 1'b1;
        cfg_addr     = 16'h0002;
        step();
        step();
        cfg_rd_valid = 1'b0;
        rst = 1'b0;
        chk("reset_core_start", {63'd0, core_start}, 64'd0);
        chk("reset_core_abort", {63'd0, core_abort}, 64'd0);
        chk("reset_buf_addr", buf_addr, 64'd0);
        step();
        step();

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].tid, vecs[i].wdata, vecs[i].exp);
        end
        step();
        step();
        chk("buf_addr_port", buf_addr, 64'hA5A5_A5A5_5A5A_5A5A);

        // Start, then completion.
        ctrl_write(64'd1);
        chk("start_pulse", {63'd0, core_start}, 64'd1);
        read_status(9'h010, 64'h0000_0000_0000_0001);
        chk("start_pulse_end", {63'd0, core_start}, 64'd0);
        done_pulse();
        read_status(9'h011, 64'h0000_0001_0000_0002);

        // Repeated starts while busy, then error clear.
        ctrl_write(64'd1);
        chk("start2_pulse", {63'd0, core_start}, 64'd1);
        ctrl_write(64'd1);
        chk("busy_start_a", {63'd0, core_start}, 64'd0);
        ctrl_write(64'd1);
        chk("busy_start_b", {63'd0, core_start}, 64'd0);
        read_status(9'h012, 64'h0000_0001_0000_0005);
        ctrl_write(64'd4);
        read_status(9'h013, 64'h0000_0001_0000_0001);

        // Abort while busy; aborts and start+abort in idle do nothing.
        ctrl_write(64'd2);
        chk("abort_pulse", {63'd0, core_abort}, 64'd1);
        read_status(9'h014, 64'h0000_0001_0000_0000);
        chk("abort_pulse_end", {63'd0, core_abort}, 64'd0);
        ctrl_write(64'd2);
        chk("idle_abort", {63'd0, core_abort}, 64'd0);
        ctrl_write(64'd3);
        chk("idle_both_start", {63'd0, core_start}, 64'd0);
        chk("idle_both_abort", {63'd0, core_abort}, 64'd0);
        read_status(9'h015, 64'h0000_0001_0000_0000);

        // Completion coinciding with a start write while busy.
        ctrl_write(64'd1);
        core_done = 1'b1;
        ctrl_write(64'd1);
        core_done = 1'b0;
        chk("coincide_start", {63'd0, core_start}, 64'd0);
        read_status(9'h016, 64'h0000_0002_0000_0006);
        done_pulse();
        read_status(9'h017, 64'h0000_0002_0000_0006);
        ctrl_write(64'd4);
        read_status(9'h018, 64'h0000_0002_0000_0002);

        // Done counter wrap from a preloaded maximum.
        force dut.done_count_r = 32'hFFFF_FFFF;
        #1;
        release dut.done_count_r;
        read_status(9'h019, 64'hFFFF_FFFF_0000_0002);
        ctrl_write(64'd1);
        done_pulse();
        read_status(9'h01A, 64'h0000_0000_0000_0002);
        step();
        step();

        // Reset while a read is in flight: no response may appear.
        cfg_rd_valid = 1'b1;
        cfg_addr     = 16'h0002;
        cfg_tid      = 9'h055;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        cfg_rd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
        end
        read_status(9'h01B, 64'd0);
        drive(1'b1, 1'b0, 16'h0010, 9'h01C, 64'd0, 64'd0);
        chk("post_reset_buf_addr", buf_addr, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
        end
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
